// File: rtl/ext_mem_pkg.sv
// rtl/ext_mem_pkg.sv - shared types and defaults for the external memory responder
package ext_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int DEF_BLOCK_WORDS = 16;
  localparam int DEF_LATENCY     = 4;
  localparam int BW_BLOCK_OFFSET = $clog2(DEF_BLOCK_WORDS);
  localparam int BW_LAT          = $clog2(DEF_LATENCY) + 1;

endpackage

// File: rtl/ext_mem_array.sv
// rtl/ext_mem_array.sv - single-port synchronous word RAM with one-cycle read latency
module ext_mem_array #(
  parameter int DEPTH_BITS = 14,
  parameter int BW_DATA    = 32
) (
  input  logic                  clock_i,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] addr,
  input  logic [BW_DATA-1:0]    wdata,
  output logic [BW_DATA-1:0]    rdata
);

  logic [BW_DATA-1:0] mem [2**DEPTH_BITS];

  always_ff @(posedge clock_i) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/external_memory_responder.sv
// rtl/external_memory_responder.sv - latency-programmable single/block word responder over an on-chip array
module external_memory_responder
  import ext_mem_pkg::*;
#(
  parameter int BW_ADDR     = 24,
  parameter int BW_DATA     = 32,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int LATENCY     = DEF_LATENCY,
  parameter int DEPTH_BITS  = 14
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               mem_req_i,
  input  logic               mem_reqBlock_i,
  input  logic               mem_clear_i,
  input  logic               mem_rw_i,
  input  logic [BW_ADDR-1:0] mem_add_i,
  input  logic [BW_DATA-1:0] mem_data_i,
  output logic [BW_DATA-1:0] mem_data_o,
  output logic               mem_done_o,
  output logic               mem_ready_o,
  output logic               mem_valid_o,
  output logic               addr_err_o
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int WC_W  = OFF_W + 1;
  localparam int LAT_W = $clog2(LATENCY) + 1;

  state_e                 state_q, state_d;
  logic [LAT_W-1:0]       lat_cnt;
  logic [WC_W-1:0]        word_cnt;
  logic [WC_W-1:0]        last_word;
  logic                   rw_q, blk_q;
  logic [DEPTH_BITS-1:0]  base_q, base_d, off, ram_addr;
  logic                   ready_q, valid_q, done_q, err_q;
  logic                   accept, abort, ram_we;
  logic [BW_DATA-1:0]     ram_rdata;

  assign accept    = ready_q & mem_req_i & ~mem_clear_i;
  assign abort     = mem_clear_i & (state_q != ST_IDLE);
  assign last_word = blk_q ? WC_W'(BLOCK_WORDS - 1) : '0;
  assign base_d    = mem_reqBlock_i ? {mem_add_i[DEPTH_BITS-1:OFF_W], {OFF_W{1'b0}}}
                                    : mem_add_i[DEPTH_BITS-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_clear_i) state_d = ST_IDLE;
        else if (lat_cnt == LAT_W'(LATENCY - 2)) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (mem_clear_i) state_d = ST_IDLE;
        else if (word_cnt == last_word) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reads run one word ahead so the registered RAM output lines up with the strobe.
  always_comb begin
    off = '0;
    if (state_q == ST_XFER) begin
      off = rw_q ? DEPTH_BITS'(word_cnt) : DEPTH_BITS'(word_cnt) + 1'b1;
    end
  end

  assign ram_addr = base_q + off;
  assign ram_we   = (state_q == ST_XFER) & rw_q & ~reset_i;

  ext_mem_array #(
    .DEPTH_BITS(DEPTH_BITS),
    .BW_DATA   (BW_DATA)
  ) u_array (
    .clock_i(clock_i),
    .we     (ram_we),
    .addr   (ram_addr),
    .wdata  (mem_data_i),
    .rdata  (ram_rdata)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rw_q     <= 1'b0;
      blk_q    <= 1'b0;
      base_q   <= '0;
      lat_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      state_q <= state_d;
      // An aborted transfer spends one idle cycle not ready before taking new work.
      ready_q <= (state_d == ST_IDLE) & ~abort;
      valid_q <= (state_d == ST_XFER);
      done_q  <= (state_d == ST_DONE);
      if (accept) begin
        rw_q     <= mem_rw_i;
        blk_q    <= mem_reqBlock_i;
        base_q   <= base_d;
        lat_cnt  <= '0;
        word_cnt <= '0;
        if (|mem_add_i[BW_ADDR-1:DEPTH_BITS]) err_q <= 1'b1;
      end else begin
        if (state_q == ST_WAIT) lat_cnt <= lat_cnt + 1'b1;
        if (state_q == ST_XFER) word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  assign mem_ready_o = ready_q;
  assign mem_valid_o = valid_q;
  assign mem_done_o  = done_q;
  assign addr_err_o  = err_q;
  assign mem_data_o  = (valid_q & ~rw_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_external_memory_responder.sv
// tb/tb_external_memory_responder.sv - scoreboard bench for external_memory_responder
module tb_external_memory_responder;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        mem_req_i, mem_reqBlock_i, mem_clear_i, mem_rw_i;
  logic [23:0] mem_add_i;
  logic [31:0] mem_data_i, mem_data_o;
  logic        mem_done_o, mem_ready_o, mem_valid_o, addr_err_o;

  typedef struct {
    bit          is_done;
    bit          chk;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  external_memory_responder dut (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .mem_req_i     (mem_req_i),
    .mem_reqBlock_i(mem_reqBlock_i),
    .mem_clear_i   (mem_clear_i),
    .mem_rw_i      (mem_rw_i),
    .mem_add_i     (mem_add_i),
    .mem_data_i    (mem_data_i),
    .mem_data_o    (mem_data_o),
    .mem_done_o    (mem_done_o),
    .mem_ready_o   (mem_ready_o),
    .mem_valid_o   (mem_valid_o),
    .addr_err_o    (addr_err_o)
  );

  always #5 clock_i = ~clock_i;
  always @(posedge clock_i) cyc++;

  always @(negedge clock_i) begin
    if (mem_valid_o === 1'b1 || mem_done_o === 1'b1) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_strobe: cycle %0d valid=%b done=%b, required no activity",
                 cyc, mem_valid_o, mem_done_o);
      end else begin
        got = sb.pop_front();
        if (got.cyc != cyc || mem_done_o !== got.is_done || mem_valid_o !== !got.is_done ||
            (got.chk && mem_data_o !== got.data)) begin
          mismatched++;
          $display("FAIL %s: cycle %0d valid=%b done=%b data=%h, required cycle %0d data=%h",
                   got.is_done ? "done_pulse" : "valid_word", cyc, mem_valid_o, mem_done_o,
                   mem_data_o, got.cyc, got.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: cycle %0d, required completion", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: cycle %0d got %h, required %h", name, cyc, act, exp);
    end
  endtask

  // mode: 0 normal, 1 clear at a+rel, 2 reset at a+rel, 3 req held through the transfer
  task automatic xfer(input logic rw, input logic blk, input logic [23:0] add,
                      input logic [31:0] pat, input int mode, input int rel);
    int   n, a, stop;
    exp_t e;
    n = blk ? 16 : 1;
    check("ready_idle", 32'(mem_ready_o), 32'd1);
    mem_req_i      = 1'b1;
    mem_reqBlock_i = blk;
    mem_rw_i       = rw;
    mem_add_i      = add;
    mem_data_i     = pat;
    a    = cyc;
    stop = (mode == 1 || mode == 2) ? a + rel : a + 4 + n;
    for (int k = 0; k < n; k++) begin
      if (a + 4 + k <= stop) begin
        e.is_done = 1'b0;
        e.chk     = !rw;
        e.data    = pat + 32'(k);
        e.cyc     = a + 4 + k;
        sb.push_back(e);
      end
    end
    if (mode == 0 || mode == 3) begin
      e.is_done = 1'b1;
      e.chk     = 1'b0;
      e.data    = '0;
      e.cyc     = a + 4 + n;
      sb.push_back(e);
    end
    tick();
    if (mode != 3) mem_req_i = 1'b0;
    while (cyc <= stop) begin
      if (cyc >= a + 4) mem_data_i = pat + 32'(cyc - a - 4);
      if (cyc == stop) begin
        if (mode == 1) mem_clear_i = 1'b1;
        else if (mode == 2) reset_i = 1'b1;
        else begin
          mem_req_i = 1'b0;
          check("ready_in_done", 32'(mem_ready_o), 32'd0);
        end
      end
      tick();
      mem_clear_i = 1'b0;
    end
    case (mode)
      1: begin
        check("ready_after_clear", 32'(mem_ready_o), 32'd0);
        check("valid_after_clear", 32'(mem_valid_o), 32'd0);
        tick();
        check("ready_clear_recover", 32'(mem_ready_o), 32'd1);
      end
      2: begin
        check("rst_valid", 32'(mem_valid_o), 32'd0);
        check("rst_ready", 32'(mem_ready_o), 32'd0);
        check("rst_done", 32'(mem_done_o), 32'd0);
        check("rst_data", mem_data_o, 32'd0);
        tick();
        reset_i = 1'b0;
        tick();
        check("rst_ready_recover", 32'(mem_ready_o), 32'd1);
      end
      default: check("ready_after_done", 32'(mem_ready_o), 32'd1);
    endcase
  endtask

  initial begin
    reset_i = 1'b1;
    mem_req_i = 1'b0;
    mem_reqBlock_i = 1'b0;
    mem_clear_i = 1'b0;
    mem_rw_i = 1'b0;
    mem_add_i = '0;
    mem_data_i = '0;
    repeat (3) tick();
    check("reset_ready", 32'(mem_ready_o), 32'd0);
    check("reset_valid", 32'(mem_valid_o), 32'd0);
    check("reset_done", 32'(mem_done_o), 32'd0);
    check("reset_err", 32'(addr_err_o), 32'd0);
    check("reset_data", mem_data_o, 32'd0);
    reset_i = 1'b0;
    tick();
    check("ready_first_edge", 32'(mem_ready_o), 32'd1);

    xfer(1'b1, 1'b0, 24'h000010, 32'hDEADBEEF, 0, 0);
    xfer(1'b0, 1'b0, 24'h000010, 32'hDEADBEEF, 0, 0);
    xfer(1'b1, 1'b1, 24'h000023, 32'h00000100, 0, 0);
    xfer(1'b0, 1'b1, 24'h00002F, 32'h00000100, 0, 0);
    xfer(1'b0, 1'b0, 24'h000023, 32'h00000103, 0, 0);
    xfer(1'b0, 1'b1, 24'h000020, 32'h00000100, 1, 6);
    xfer(1'b0, 1'b0, 24'h000010, 32'hDEADBEEF, 0, 0);
    xfer(1'b0, 1'b0, 24'h000010, 32'hDEADBEEF, 3, 0);

    mem_req_i   = 1'b1;
    mem_clear_i = 1'b1;
    tick();
    mem_req_i   = 1'b0;
    mem_clear_i = 1'b0;
    repeat (8) tick();
    check("ready_after_req_clear", 32'(mem_ready_o), 32'd1);

    xfer(1'b1, 1'b0, 24'h000005, 32'hA5A50005, 0, 0);
    check("err_before", 32'(addr_err_o), 32'd0);
    xfer(1'b0, 1'b0, 24'h004005, 32'hA5A50005, 0, 0);
    check("err_set", 32'(addr_err_o), 32'd1);
    xfer(1'b0, 1'b0, 24'h000010, 32'hDEADBEEF, 0, 0);
    check("err_sticky", 32'(addr_err_o), 32'd1);

    xfer(1'b1, 1'b1, 24'h000040, 32'h00000200, 2, 6);
    check("err_cleared_by_reset", 32'(addr_err_o), 32'd0);
    xfer(1'b0, 1'b0, 24'h000040, 32'h00000200, 0, 0);
    xfer(1'b0, 1'b0, 24'h000041, 32'h00000201, 0, 0);

    repeat (4) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
